mult_booth: RTL and testbench

- Sequential signed multiplier using radix-2 Booth, one step per clock.
- Sits directly upstream of the datapath's generic write-back/HI-LO selection muxes. Its hi/lo results are mux data inputs; its done pulse tells the control unit when to switch the mux select and write.
- Started by the control unit for MULT; holds its result until the next multiplication completes.

---
 rtl/mult_booth.sv | 113 +++++++++++
 tb/tb_mult_booth.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mult_booth.sv
// Sequential signed radix-2 Booth multiplier: one Booth step per clock,
// full 2*WIDTH signed product presented on hi/lo with a one-cycle done pulse.
module mult_booth #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    // One guard bit on A and M keeps A-M exact when M is the most negative value.
    logic [WIDTH:0]     acc_q;
    logic [WIDTH:0]     m_q;
    logic [WIDTH-1:0]   q_q;
    logic               qm1_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH:0]     sum_d;
    logic [WIDTH:0]     acc_d;
    logic [WIDTH-1:0]   q_d;
    logic               qm1_d;

    // Booth add/subtract followed by the arithmetic right shift of {A,Q,q_-1}.
    always_comb begin
        sum_d = acc_q;
        unique case ({q_q[0], qm1_q})
            2'b01:   sum_d = acc_q + m_q;
            2'b10:   sum_d = acc_q - m_q;
            default: sum_d = acc_q;
        endcase
        acc_d = {sum_d[WIDTH], sum_d[WIDTH:1]};
        q_d   = {sum_d[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_q     <= {a[WIDTH-1], a};
                        q_q     <= b;
                        acc_q   <= '0;
                        qm1_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        hi_q    <= acc_d[WIDTH-1:0];
                        lo_q    <= q_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_booth.sv
// Directed-vector bench for mult_booth: latency, signed extremes, ignored
// starts, asynchronous reset mid-operation and back-to-back throughput.
module tb_mult_booth;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_cmp;
    int n_err;

    mult_booth #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one multiplication; inj >= 0 pulses a stray start with new operands
    // at that many cycles into the run.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input int inj);
        int busy_cnt;
        int done_at;
        int done_cnt;
        int busy_at_done;
        logic [W-1:0] hi_seen;
        logic [W-1:0] lo_seen;
        busy_cnt = 0; done_at = -1; done_cnt = 0; busy_at_done = 0;
        hi_seen = '0; lo_seen = '0;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = j; hi_seen = hi; lo_seen = lo; busy_at_done = int'(busy);
                end
            end
            if (j == inj) begin
                start = 1'b1; a = 9; b = 9;
            end else if (j == inj + 1) begin
                start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
            end
        end
        $display("op %s: a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h busy_cycles=%0d done_at=%0d",
                 tag, av, bv, hi_seen, lo_seen, busy_cnt, done_at);
        check_eq({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd32);
        check_eq({tag, ".done_at"}, 64'(done_at), 64'd32);
        check_eq({tag, ".done_cnt"}, 64'(done_cnt), 64'd1);
        check_eq({tag, ".busy_at_done"}, 64'(busy_at_done), 64'd0);
        check_eq({tag, ".product"}, {hi_seen, lo_seen}, {exp_hi, exp_lo});
        check_eq({tag, ".hold"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int stray_done;
        int hold_bad;
        int dones;
        int bad_gap;
        int bad_val;
        int last_done;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;

        repeat (2) @(negedge clk);
        check_eq("reset.outputs", {60'd0, busy, done, |hi, |lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle.outputs", {60'd0, busy, done, |hi, |lo}, 64'd0);

        run_op("basic_7x3",    32'd7,          32'd3,          32'h0000_0000, 32'h0000_0015, -1);
        run_op("neg5x3",       32'hFFFF_FFFB,  32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFF1, -1);
        run_op("3xneg5",       32'd3,          32'hFFFF_FFFB,  32'hFFFF_FFFF, 32'hFFFF_FFF1, -1);
        run_op("min_x_min",    32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, -1);
        run_op("m1_x_m1",      32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001, -1);
        run_op("max_x_min",    32'h7FFF_FFFF,  32'h8000_0000,  32'hC000_0000, 32'h8000_0000, -1);
        run_op("ignore_start", 32'd2,          32'd2,          32'h0000_0000, 32'h0000_0004, 10);

        // Asynchronous reset in the middle of a 6x6 run.
        run_op("pre_reset",    32'd7,          32'd3,          32'h0000_0000, 32'h0000_0015, -1);
        @(negedge clk);
        a = 6; b = 6; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 0; j < 15; j++) @(negedge clk);
        check_eq("pre_reset.busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        $display("op reset_midop: busy=%0d done=%0d hi=0x%08h lo=0x%08h", busy, done, hi, lo);
        check_eq("reset_midop.outputs", {busy, done, 30'd0, hi ^ lo}, 64'd0);
        check_eq("reset_midop.product", {hi, lo}, 64'd0);
        stray_done = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (done || busy) stray_done++;
        end
        rst_n = 1'b1;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            if (done || busy) stray_done++;
        end
        check_eq("reset_midop.no_done", 64'(stray_done), 64'd0);
        run_op("after_reset",  32'd6,          32'd6,          32'h0000_0000, 32'h0000_0024, -1);

        // Idle hold of the previous result.
        run_op("hold_7x3",     32'd7,          32'd3,          32'h0000_0000, 32'h0000_0015, -1);
        hold_bad = 0;
        a = 32'hFFFF_0000; b = 32'h0000_FFFF;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (hi !== 32'd0 || lo !== 32'd21 || busy || done) hold_bad++;
        end
        $display("op hold_50: hi=0x%08h lo=0x%08h bad_cycles=%0d", hi, lo, hold_bad);
        check_eq("hold.bad_cycles", 64'(hold_bad), 64'd0);

        // Start held high: one result every WIDTH+2 cycles.
        dones = 0; bad_gap = 0; bad_val = 0; last_done = -1;
        a = 2; b = 5; start = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 106; j++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (last_done < 0 ? (j != 32) : (j - last_done != 34)) bad_gap++;
                if (hi !== 32'd0 || lo !== 32'd10 || busy) bad_val++;
                last_done = j;
                $display("op b2b_2x5: done_at=%0d hi=0x%08h lo=0x%08h", j, hi, lo);
            end
        end
        start = 1'b0;
        check_eq("b2b.done_count", 64'(dones), 64'd3);
        check_eq("b2b.bad_gap", 64'(bad_gap), 64'd0);
        check_eq("b2b.bad_value", 64'(bad_val), 64'd0);

        repeat (40) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
